div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK and RESET; no other clock or reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request a division; sampled only in IDLE.
REQ-005 OP  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-006 A  input  32  dividend; sampled on the accepting edge.
REQ-007 B  input  32  divisor; sampled on the accepting edge.
REQ-008 BUSY  output  1  high while a request is in progress (RUN or FINISH).
REQ-009 DONE  output  1  one-cycle pulse; RESULT is valid while high.
REQ-010 RESULT  output  32  quotient or remainder of the last completed request; held until the next DONE.

Function
REQ-011 FSM states SHALL be IDLE, RUN and FINISH; BUSY = (state != IDLE).
REQ-012 IDLE with START=1 at edge 0 SHALL latch OP, magnitude-adjusted operands and sign flags.
- If B != 0, the FSM goes to RUN with step counter = 0.
- If B == 0, the FSM goes directly to FINISH.
REQ-013 START while BUSY=1 SHALL be ignored, with no effect on the operation in progress.
REQ-014 RUN SHALL perform one restoring-division step per edge.
- Partial remainder R (32b) and quotient register Q (32b).
- Trial = {R[30:0], Q[31]} - divisor |B|, computed through Adder32b with SUB=1.
- If COUT=1 (no borrow): R = trial and shift 1 into Q; otherwise R = {R[30:0], Q[31]} and shift 0 into Q.
REQ-015 RUN SHALL last exactly 32 edges (counter 0..31) and then go to FINISH.
REQ-016 FINISH SHALL register the result, set DONE=1 for exactly one cycle and return to IDLE on the same edge.
- Non-zero B: DONE is high in the cycle after edge 33, counting from the accepting edge 0.
- B == 0: DONE is high in the cycle after edge 1.
REQ-017 Signed operands (DIV, REM) SHALL be converted to 32b unsigned magnitudes before RUN.
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
- Negation happens in FINISH.
REQ-018 Divide by zero SHALL give RISC-V results.
- DIV and DIVU: RESULT = 0xFFFFFFFF.
- REM and REMU: RESULT = A as sampled.
REQ-019 DIV with A=0x80000000, B=0xFFFFFFFF SHALL give RESULT=0x80000000; REM with the same operands SHALL give 0x00000000; no trap.
REQ-020 A and B changing after the accepting edge SHALL not affect the result.
REQ-021 A START held high through DONE SHALL be accepted on the first edge in IDLE after DONE, so back-to-back operation is allowed.

Reset
REQ-022 RESET=1 SHALL immediately force the state to IDLE and clear BUSY, DONE, RESULT, R, Q and the counter to 0, including in the middle of RUN or FINISH.
REQ-023 After RESET deasserts, the first edge with START=1 SHALL begin a fresh operation; no partial result from an aborted operation is ever reported.

Structure
REQ-024 A shared package SHALL hold:
- the OP encodings (DIV, DIVU, REM, REMU);
- the FSM state encoding;
- the constant XLEN=32 and the step count 32.
REQ-025 The subtractor SHALL be one instance of the existing Adder32b (A, B, SUB, S, COUT), with SUB tied to 1; the block SHALL not contain a second adder for the trial subtraction.
REQ-026 Sign negation in FINISH MAY use a separate combinational two's-complement; no further sub-modules.

Verification
REQ-027 DIVU, A=100, B=7, START for 1 cycle -> BUSY high for 33 cycles, DONE 1 cycle, RESULT=14; then REMU same operands -> RESULT=2.
REQ-028 DIV, A=-100 (0xFFFFFF9C), B=7 -> RESULT=0xFFFFFFF2 (-14); REM, A=-100, B=7 -> RESULT=0xFFFFFFFE (-2).
REQ-029 DIV, A=0x80000000, B=0xFFFFFFFF -> 0x80000000; DIVU, A=5, B=0 -> 0xFFFFFFFF with DONE two cycles after START; REMU, A=5, B=0 -> 5.
REQ-030 START pulsed again at cycle 10 of a DIVU 100/7 operation -> ignored, single DONE, RESULT=14.
REQ-031 RESET asserted at cycle 15 of RUN -> BUSY, DONE and RESULT are 0 asynchronously; no DONE follows; a new DIVU 9/3 gives RESULT=3.
REQ-032 Randomised DIV, DIVU, REM and REMU against a reference model, including B=0, B=1, A=0 and A=B cases, with zero mismatches and a reported error count.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Holds op encodings, FSM states and the negate helper.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int STEPS = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  function automatic logic [XLEN-1:0] neg(
    input logic [XLEN-1:0] x
  );
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_unit_adder.sv
// 32-bit adder/subtractor shared by the divider.
// SUB=1 computes A-B; COUT=1 then means no borrow.
module Adder32b (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SUB,
  output logic [31:0] S,
  output logic        COUT
);

  logic [31:0] b_eff;

  assign b_eff = SUB ? ~B : B;
  assign {COUT, S} = {1'b0, A} + {1'b0, b_eff}
                   + {32'd0, SUB};

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// 32 RUN steps, sign fix-up and RISC-V corner cases in FINISH.
module div_unit
  import div_unit_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  output logic             BUSY,
  output logic             DONE,
  output logic [XLEN-1:0]  RESULT
);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] shifted, trial;
  logic [XLEN-1:0] quo, rem, fin;
  logic            cout, take;
  logic            sgn, sa, sb, is_rem;

  assign shifted = {r_q[XLEN-2:0], q_q[XLEN-1]};

  Adder32b u_sub (
    .A    (shifted),
    .B    (dvs_q),
    .SUB  (1'b1),
    .S    (trial),
    .COUT (cout)
  );

  // A set R[31] means the shifted value exceeds 2^32, so it always fits.
  assign take = cout | r_q[XLEN-1];

  assign is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  assign quo    = negq_q ? neg(q_q) : q_q;
  assign rem    = negr_q ? neg(r_q) : r_q;

  always_comb begin
    fin = is_rem ? rem : quo;
    if (dz_q)
      fin = is_rem ? (negr_q ? neg(q_q) : q_q)
                   : {XLEN{1'b1}};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    res_d   = res_q;
    done_d  = 1'b0;
    sgn     = (OP == OP_DIV) || (OP == OP_REM);
    sa      = sgn & A[XLEN-1];
    sb      = sgn & B[XLEN-1];
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          op_d    = op_e'(OP);
          q_d     = sa ? neg(A) : A;
          dvs_d   = sb ? neg(B) : B;
          r_d     = '0;
          cnt_d   = '0;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          dz_d    = (B == '0);
          state_d = (B == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        r_d   = take ? trial : shifted;
        q_d   = {q_q[XLEN-2:0], take};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(STEPS - 1))
          state_d = ST_FINISH;
      end
      ST_FINISH: begin
        res_d   = fin;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DIV;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;
  assign RESULT = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M cases plus
// randomized ops against an arithmetic reference model.
module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] A, B;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int checks   = 0;
  int failures = 0;
  int dones    = 0;
  logic [31:0] sb[$];

  div_unit dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OP     (OP),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int signed sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 0)
      return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b01: return a / b;
      2'b11: return a % b;
      2'b00: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return sa / sbv;
      end
      default: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        return sa % sbv;
      end
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // monitor: every DONE pops one expectation
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=%h exp=none",
                 RESULT);
      end else begin
        chk("result", RESULT, sb.pop_front());
      end
    end
  end

  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int glitch_at);
    int lat, busy, want;
    want = (b == 0) ? 1 : 33;
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b;
    sb.push_back(model(op, a, b));
    @(posedge CLK); #1;
    START = 1'b0;
    A = $urandom; B = $urandom; OP = 2'($urandom);
    busy = BUSY ? 1 : 0;
    lat  = 0;
    for (int k = 1; k <= 60; k++) begin
      START = (k == glitch_at);
      @(posedge CLK); #1;
      if (DONE) begin
        lat = k;
        break;
      end
      if (BUSY) busy++;
    end
    START = 1'b0;
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL done_timeout got=none exp=%0d", want);
    end else begin
      chk("latency", lat, want);
      chk("busy_cycles", busy, want);
    end
  endtask

  initial begin
    int lat, d0;
    logic [31:0] a, b;
    logic [1:0]  op;
    RESET = 1'b1; START = 1'b0; OP = 2'b00;
    A = '0; B = '0;
    #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    do_op(2'b01, 32'd100, 32'd7, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 0);
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b01, 32'd5, 32'd0, 0);
    do_op(2'b11, 32'd5, 32'd0, 0);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    // stray START mid-run must be ignored
    do_op(2'b01, 32'd100, 32'd7, 10);

    // back-to-back with START held through DONE
    @(negedge CLK);
    START = 1'b1; OP = 2'b01; A = 32'd100; B = 32'd7;
    sb.push_back(32'd14);
    @(posedge CLK); #1;
    OP = 2'b11;
    sb.push_back(32'd2);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = k; break; end
    end
    chk("b2b_lat1", lat, 33);
    @(posedge CLK); #1;
    START = 1'b0;
    chk("b2b_accept", {31'd0, BUSY}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = k; break; end
    end
    chk("b2b_lat2", lat, 33);

    // asynchronous reset in the middle of RUN
    @(negedge CLK);
    START = 1'b1; OP = 2'b01; A = 32'd100; B = 32'd7;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (15) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_busy", {31'd0, BUSY}, 32'd0);
    chk("arst_done", {31'd0, DONE}, 32'd0);
    chk("arst_result", RESULT, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    d0 = dones;
    repeat (40) @(negedge CLK);
    chk("no_stale_done", dones, d0);
    do_op(2'b01, 32'd9, 32'd3, 0);

    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: a = 32'd0;
        3: b = a;
        4: begin a = 32'h8000_0000; b = '1; end
        5: b = $urandom_range(1, 300);
        6: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: ;
      endcase
      do_op(op, a, b, 0);
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
